// File: rtl/ramp_pkg.sv
// Shared types and defaults for the LED ramp sequencer: FSM states, rate codes
// and the default tick-divider periods for a 50 MHz clock.
package ramp_pkg;

  localparam int unsigned WIDTH_DEF       = 8;
  localparam int unsigned DIV0_DEF        = 20_000_000;
  localparam int unsigned DIV1_DEF        = 10_000_000;
  localparam int unsigned DIV2_DEF        = 5_000_000;
  localparam int unsigned DIV3_DEF        = 2_500_000;
  localparam int unsigned DWELL_TICKS_DEF = 4;

  localparam logic [1:0] RATE_0 = 2'd0;
  localparam logic [1:0] RATE_1 = 2'd1;
  localparam logic [1:0] RATE_2 = 2'd2;
  localparam logic [1:0] RATE_3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_UP,
    ST_DWELL_TOP,
    ST_RAMP_DOWN,
    ST_DWELL_BOT
  } state_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ramp_sequencer_tick_divider.sv
// Selectable-rate tick generator: counts 0..DIV[rate]-1 and asserts a one-cycle
// tick on the terminal count. A rate change or an explicit clear restarts it.
module tick_divider
  import ramp_pkg::*;
#(
  parameter int unsigned DIV0 = DIV0_DEF,
  parameter int unsigned DIV1 = DIV1_DEF,
  parameter int unsigned DIV2 = DIV2_DEF,
  parameter int unsigned DIV3 = DIV3_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_rate,
  input  logic       i_clear,
  output logic       o_tick
);

  localparam int unsigned DIV_MAX = max4(DIV0, DIV1, DIV2, DIV3);
  localparam int unsigned CW      = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_rate;
  logic [CW-1:0] w_term;
  logic          w_rate_chg;
  logic          w_at_term;

  always_comb begin
    w_term = '0;
    unique case (i_rate)
      RATE_0:  w_term = CW'(DIV0 - 1);
      RATE_1:  w_term = CW'(DIV1 - 1);
      RATE_2:  w_term = CW'(DIV2 - 1);
      default: w_term = CW'(DIV3 - 1);
    endcase
  end

  // A new rate takes effect immediately: the stale count is discarded and no
  // tick is issued in the switching cycle.
  assign w_rate_chg = (i_rate != r_rate);
  assign w_at_term  = (r_cnt == w_term);
  assign o_tick     = w_at_term && !w_rate_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rate <= i_rate;
    end else begin
      r_rate <= i_rate;
      if (i_clear || w_rate_chg || w_at_term) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ramp_sequencer.sv
// Triangle-pattern controller for the LED up/down counter: clear, ramp up to a
// latched limit, dwell, ramp down to zero, dwell, then loop or finish.
module ramp_sequencer
  import ramp_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned DIV0        = DIV0_DEF,
  parameter int unsigned DIV1        = DIV1_DEF,
  parameter int unsigned DIV2        = DIV2_DEF,
  parameter int unsigned DIV3        = DIV3_DEF,
  parameter int unsigned DWELL_TICKS = DWELL_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [1:0]       rate,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count,
  output logic             inc,
  output logic             dec,
  output logic             clr,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_limit;
  logic [DW-1:0]    r_dwell;
  logic             r_inc;
  logic             r_dec;
  logic             r_clr;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_launch;
  logic             w_dwell_last;

  assign w_launch     = (r_state == ST_IDLE) && start && !stop;
  assign w_dwell_last = (r_dwell == DW'(DWELL_TICKS - 1));

  tick_divider #(
    .DIV0 (DIV0),
    .DIV1 (DIV1),
    .DIV2 (DIV2),
    .DIV3 (DIV3)
  ) u_tick_divider (
    .clk     (clk),
    .rst     (rst),
    .i_rate  (rate),
    .i_clear (w_launch),
    .o_tick  (w_tick)
  );

  // Strobes default low each cycle; stop overrides any tick-driven action so
  // the counter is left exactly where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_limit <= '0;
      r_dwell <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_inc  <= 1'b0;
      r_dec  <= 1'b0;
      r_clr  <= 1'b0;
      r_done <= 1'b0;
      if (stop) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_limit <= limit;
              r_clr   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_RAMP_UP;
            end
          end
          ST_RAMP_UP: begin
            if (w_tick) begin
              if (count >= r_limit) begin
                r_state <= ST_DWELL_TOP;
                r_dwell <= '0;
              end else begin
                r_inc <= 1'b1;
              end
            end
          end
          ST_DWELL_TOP: begin
            if (w_tick) begin
              if (w_dwell_last) begin
                r_state <= ST_RAMP_DOWN;
                r_dwell <= '0;
              end else begin
                r_dwell <= r_dwell + 1'b1;
              end
            end
          end
          ST_RAMP_DOWN: begin
            if (w_tick) begin
              if (count == '0) begin
                r_state <= ST_DWELL_BOT;
                r_dwell <= '0;
              end else begin
                r_dec <= 1'b1;
              end
            end
          end
          ST_DWELL_BOT: begin
            if (w_tick) begin
              if (w_dwell_last) begin
                r_dwell <= '0;
                if (loop) begin
                  r_state <= ST_RAMP_UP;
                end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end else begin
                r_dwell <= r_dwell + 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign inc  = r_inc;
  assign dec  = r_dec;
  assign clr  = r_clr;
  assign busy = r_busy;
  assign done = r_done;

endmodule
